imem_responder: RTL and testbench

- Instruction-memory responder; the memory end of the core's fetch interface. The fetch unit is the initiator.
- Accepts word-addressed fetch requests over a valid/ready channel.
- Returns the instruction word after a fixed, configurable latency over a second valid/ready channel.
- Supports a redirect flush for taken branches and jumps, plus a load port used by benches and the boot path to fill the array.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/imem_array.sv | 46 ++++
 rtl/imem_responder.sv | 143 ++++++++++++++
 tb/tb_imem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the instruction-memory responder state type.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- returned for fetches outside the array
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Width of the latency down-counter; covers LATENCY up to 15
    localparam int unsigned IMEM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage : rv32i_pkg

// File: rtl/imem_array.sv
// Synchronous 1R1W instruction word array. A read and a write to the same
// index in one cycle return the old word (read-before-write). The read data
// register only updates on i_rd_en, so it holds the fetched word steady for
// as long as the responder needs it.
module imem_array
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_rd_en,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data
);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_rd_data;
    logic            w_wr_in_range;

    // Indices past the last word exist only when DEPTH is not a power of two
    assign w_wr_in_range = ({1'b0, i_wr_addr} < (AW + 1)'(DEPTH));

    // Array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; samples the pre-write word on a same-index collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : imem_array

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory side of the fetch interface.
// Accepts one word-addressed request at a time, returns the word LATENCY
// cycles after the accept cycle, and drops in-flight work on flush.
module imem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic                     busy
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = IMEM_CNT_W;
    localparam bit          LAT1  = (LATENCY == 1);

    imem_state_e            r_state;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;
    logic                   r_rsp_valid;
    logic                   r_busy;

    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_rd_en;
    logic [XLEN-1:0]        w_rd_data;

    // Full-width range check so addresses at or past DEPTH never alias low words
    assign w_in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));

    // Ready while idle, or in the response cycle the initiator is consuming;
    // flush and reset both block acceptance
    assign req_ready = rst_n && !flush &&
                       ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));

    assign w_accept = req_valid && req_ready;

    // The array read happens in the accept cycle; its read register is the
    // data half of the holding register
    assign w_rd_en = w_accept && w_in_range;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (req_addr[AW-1:0]),
        .o_rd_data (w_rd_data),
        .i_wr_en   (load_en),
        .i_wr_addr (AW'(load_addr)),
        .i_wr_data (load_data)
    );

    // Responder FSM, latency counter and error flag; outputs registered with state.
    // The counter starts at LATENCY-1 and WAIT hands over to RESP on the cycle it
    // would reach zero, giving LATENCY-1 WAIT cycles between accept and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_err       <= !w_in_range;
                        r_count     <= CNT_W'(LATENCY - 1);
                        r_state     <= LAT1 ? RESP : WAIT;
                        r_rsp_valid <= LAT1;
                        r_busy      <= 1'b1;
                    end
                end

                WAIT: begin
                    if (flush) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_count <= CNT_W'(1)) begin
                        r_state     <= RESP;
                        r_count     <= '0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_count     <= r_count - CNT_W'(1);
                    end
                end

                RESP: begin
                    // Handshake or flush ends this response; a same-cycle accept
                    // (never possible under flush) chains the next one
                    if (flush || rsp_ready) begin
                        if (w_accept) begin
                            r_err       <= !w_in_range;
                            r_count     <= CNT_W'(LATENCY - 1);
                            r_state     <= LAT1 ? RESP : WAIT;
                            r_rsp_valid <= LAT1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_count     <= '0;
                            r_rsp_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_count     <= '0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range fetches return a NOP; both sources are held registers, so
    // the response stays stable until consumed
    assign rsp_data  = r_err ? NOP_INSTR : w_rd_data;
    assign rsp_err   = r_err;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with DEPTH=256, LATENCY=2.
module tb_imem_responder;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              flush;
    logic              load_en;
    logic [7:0]        load_addr;
    logic [31:0]       load_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    imem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle (rsp_ready left as set by caller)
    task automatic issue(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset state
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        req_valid = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Fill words 0..7 with 0x100+i
        for (int i = 0; i < 8; i++) begin
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = 32'h100 + 32'(i);
            tick();
        end
        load_en = 1'b0;

        // Single fetch of addr 3: valid in the second cycle after the accept cycle
        rsp_ready = 1'b1;
        issue(32'd3);
        check("lat_wait_valid", 32'(rsp_valid), 32'd0);
        check("lat_wait_busy",  32'(busy),      32'd1);
        tick();
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        check("lat_resp_data",  rsp_data,       32'h103);
        check("lat_resp_err",   32'(rsp_err),   32'd0);
        check("lat_resp_busy",  32'(busy),      32'd1);
        tick();
        check("lat_idle_valid", 32'(rsp_valid), 32'd0);
        check("lat_idle_busy",  32'(busy),      32'd0);

        // Back-to-back 0,1,2: next accept happens in each response cycle
        req_valid = 1'b1;
        req_addr  = 32'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("b2b_wait_valid", 32'(rsp_valid), 32'd0);
            check("b2b_wait_ready", 32'(req_ready), 32'd0);
            tick();
            check("b2b_resp_valid", 32'(rsp_valid), 32'd1);
            check("b2b_resp_data",  rsp_data,       32'h100 + 32'(i));
            if (i < 2) begin
                req_addr = 32'(i + 1);
                #1;
                check("b2b_resp_ready", 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Stall rsp_ready for 5 cycles in RESP
        rsp_ready = 1'b0;
        issue(32'd4);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data",  rsp_data,       32'h104);
            check("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("stall_release_valid", 32'(rsp_valid), 32'd1);
        check("stall_release_data",  rsp_data,       32'h104);
        tick();
        check("stall_done_valid", 32'(rsp_valid), 32'd0);
        check("stall_done_busy",  32'(busy),      32'd0);

        // Flush one cycle after accepting addr 5
        issue(32'd5);
        flush = 1'b1;
        #1;
        check("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_idle_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        issue(32'd6);
        tick();
        check("post_flush_valid", 32'(rsp_valid), 32'd1);
        check("post_flush_data",  rsp_data,       32'h106);
        tick();

        // Flush with req_valid: request must not be accepted
        flush = 1'b1;
        issue(32'd7);
        flush = 1'b0;
        check("flush_req_busy", 32'(busy), 32'd0);
        tick();
        check("flush_req_no_rsp", 32'(rsp_valid), 32'd0);
        check("flush_req_busy2",  32'(busy),      32'd0);

        // Out-of-range: DEPTH exactly, and an address whose low bits alias word 3
        issue(32'd256);
        tick();
        check("oob256_valid", 32'(rsp_valid), 32'd1);
        check("oob256_data",  rsp_data,       32'h0000_0013);
        check("oob256_err",   32'(rsp_err),   32'd1);
        tick();
        issue(32'h0001_0003);
        tick();
        check("oob_hi_data", rsp_data,     32'h0000_0013);
        check("oob_hi_err",  32'(rsp_err), 32'd1);
        tick();

        // Same-cycle load and accept of addr 2: old word returned
        load_en   = 1'b1;
        load_addr = 8'd2;
        load_data = 32'hDEAD;
        issue(32'd2);
        load_en = 1'b0;
        tick();
        check("rbw_data", rsp_data,     32'h102);
        check("rbw_err",  32'(rsp_err), 32'd0);
        tick();
        issue(32'd2);
        tick();
        check("rbw_new_data", rsp_data, 32'hDEAD);
        tick();

        // Load after accept does not alter the in-flight word
        issue(32'd1);
        load_en   = 1'b1;
        load_addr = 8'd1;
        load_data = 32'hBEEF;
        tick();
        load_en = 1'b0;
        check("inflight_data", rsp_data, 32'h101);
        tick();

        // Reset while in WAIT; array contents survive
        issue(32'd4);
        check("rstw_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_valid", 32'(rsp_valid), 32'd0);
        check("rstw_busy",  32'(busy),      32'd0);
        check("rstw_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("rstw_after_valid", 32'(rsp_valid), 32'd0);
        issue(32'd4);
        tick();
        check("retain_valid", 32'(rsp_valid), 32'd1);
        check("retain_data",  rsp_data,       32'h104);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_responder
